// File: rtl/fp_add_normalizer.sv
// Post-add normalizer: takes the raw adder result {sign, exp, carry.implicit.fraction},
// brings it to 1.M form (one right shift on carry, or one left shift per cycle)
// and packs an IEEE-754 style word behind valid/ready handshakes.
// Build option: FPN_FTZ_EN -- flush subnormal results to signed zero.
//
//  state   | meaning
//  S_IDLE  | waiting for an operand, in_ready=1
//  S_SHIFT | normalizing, one rule applied per cycle
//  S_DONE  | result presented, out_valid=1 until out_ready
module fp_add_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_man,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_zero,
  output logic                   out_denorm,
  output logic                   out_ovf
);

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [MAN_W-1:0] FRAC_ZERO = {MAN_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_n;
  logic                   sign_q, sign_n;
  logic [EXP_W-1:0]       exp_q, exp_n;
  logic [MAN_W+1:0]       man_q, man_n;
  logic                   special_q, special_n;
  logic [EXP_W+MAN_W:0]   data_q, data_n;
  logic                   zero_q, zero_n;
  logic                   denorm_q, denorm_n;
  logic                   ovf_q, ovf_n;
  logic [EXP_W-1:0]       exp_inc;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_data   = data_q;
  assign out_zero   = zero_q;
  assign out_denorm = denorm_q;
  assign out_ovf    = ovf_q;

  assign exp_inc = exp_q + EXP_ONE;

  // State and datapath registers; reset discards any in-flight operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      exp_q     <= EXP_ZERO;
      man_q     <= '0;
      special_q <= 1'b0;
      data_q    <= '0;
      zero_q    <= 1'b0;
      denorm_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      sign_q    <= sign_n;
      exp_q     <= exp_n;
      man_q     <= man_n;
      special_q <= special_n;
      data_q    <= data_n;
      zero_q    <= zero_n;
      denorm_q  <= denorm_n;
      ovf_q     <= ovf_n;
    end
  end

  // Next-state and normalization rules; first matching rule wins in S_SHIFT.
  always_comb begin
    state_n   = state_q;
    sign_n    = sign_q;
    exp_n     = exp_q;
    man_n     = man_q;
    special_n = special_q;
    data_n    = data_q;
    zero_n    = zero_q;
    denorm_n  = denorm_q;
    ovf_n     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_n    = in_sign;
          // exponent 0 carries the same weight as 1 (subnormal input)
          exp_n     = (in_exp == EXP_ZERO) ? EXP_ONE : in_exp;
          man_n     = in_man;
          special_n = (in_exp == EXP_ONES);
          zero_n    = 1'b0;
          denorm_n  = 1'b0;
          ovf_n     = 1'b0;
          state_n   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (special_q) begin
          data_n  = {sign_q, EXP_ONES, man_q[MAN_W-1:0]};
          state_n = S_DONE;
        end else if (man_q[MAN_W+1]) begin
          // after one right shift the implicit bit is set, so finish directly
          if (exp_inc == EXP_ONES) begin
            data_n = {sign_q, EXP_ONES, FRAC_ZERO};
            ovf_n  = 1'b1;
          end else begin
            data_n = {sign_q, exp_inc, man_q[MAN_W:1]};
          end
          state_n = S_DONE;
        end else if (man_q == '0) begin
          data_n  = {sign_q, EXP_ZERO, FRAC_ZERO};
          zero_n  = 1'b1;
          state_n = S_DONE;
        end else if (man_q[MAN_W]) begin
          data_n  = {sign_q, exp_q, man_q[MAN_W-1:0]};
          state_n = S_DONE;
        end else if (exp_q == EXP_ONE) begin
`ifdef FPN_FTZ_EN
          data_n  = {sign_q, EXP_ZERO, FRAC_ZERO};
          zero_n  = 1'b1;
`else
          data_n   = {sign_q, EXP_ZERO, man_q[MAN_W-1:0]};
          denorm_n = 1'b1;
`endif
          state_n = S_DONE;
        end else begin
          man_n = {man_q[MAN_W:0], 1'b0};
          exp_n = exp_q - EXP_ONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
